// File: rtl/fft64_pkg.sv
// Shared constants and FSM encoding for the fft64 frame sequencer.
// Sample k of a reader word: re at [LANE*k+RE_LSB +: W], im at [LANE*k+IM_LSB +: W].
package fft64_pkg;
    localparam int N      = 64;
    localparam int W      = 11;
    localparam int SPW    = 4;
    localparam int RE_LSB = 16;
    localparam int IM_LSB = 0;
    localparam int LANE   = 32;
    localparam int WORD_W = LANE * SPW;
    localparam int SIDX_W = $clog2(SPW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FEED,
        ST_DRAIN
    } state_t;
endpackage

// File: rtl/fft64_frame_ctrl_if.sv
// Bundle of control, reader, fft64 and sink signals around the frame sequencer.
// master = sequencer view, slave = surrounding environment view.
interface fft64_frame_ctrl_if;
    import fft64_pkg::*;

    logic                start;
    logic [7:0]          nframes;
    logic                busy;
    logic [WORD_W-1:0]   reader_data;
    logic                reader_empty;
    logic                reader_en;
    logic                valid_a;
    logic signed [W-1:0] ar;
    logic signed [W-1:0] ai;
    logic                full;
    logic                valid_o;
    logic signed [W-1:0] xr;
    logic signed [W-1:0] xi;
    logic                rd_en;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic [5:0]          out_idx;
    logic                frame_done;

    modport master (
        input  start, nframes, reader_data, reader_empty, full, valid_o, xr, xi, out_ready,
        output busy, reader_en, valid_a, ar, ai, rd_en, out_valid, out_re, out_im, out_idx,
               frame_done
    );

    modport slave (
        output start, nframes, reader_data, reader_empty, full, valid_o, xr, xi, out_ready,
        input  busy, reader_en, valid_a, ar, ai, rd_en, out_valid, out_re, out_im, out_idx,
               frame_done
    );
endinterface

// File: rtl/fft64_word_unpack.sv
// Combinational lane select: picks sample i_sidx (re/im) out of a packed reader word.
module fft64_word_unpack
    import fft64_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [SIDX_W-1:0] i_sidx,
    output logic signed [W-1:0] o_re,
    output logic signed [W-1:0] o_im
);
    logic [W-1:0]   w_re [SPW];
    logic [W-1:0]   w_im [SPW];
    logic [SPW-1:0] w_unused_pad;

    for (genvar gi = 0; gi < SPW; gi++) begin : g_lane
        assign w_re[gi] = i_word[gi*LANE+RE_LSB +: W];
        assign w_im[gi] = i_word[gi*LANE+IM_LSB +: W];
        // Padding bits between the fields carry nothing.
        assign w_unused_pad[gi] = ^{i_word[gi*LANE+IM_LSB+W +: RE_LSB-IM_LSB-W],
                                    i_word[gi*LANE+RE_LSB+W +: LANE-RE_LSB-W]};
    end

    assign o_re = w_re[i_sidx];
    assign o_im = w_im[i_sidx];
endmodule

// File: rtl/fft64_frame_ctrl.sv
// Frame sequencer: fetches packed reader words, feeds N samples into fft64,
// then drains N bins into a ready/valid sink, for nframes frames per run.
module fft64_frame_ctrl
    import fft64_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    fft64_frame_ctrl_if.master bus
);
    state_t              r_state;
    state_t              w_state_next;
    logic                r_fetch_pend;
    logic [WORD_W-1:0]   r_buf;
    logic [SIDX_W-1:0]   r_sidx;
    logic [6:0]          r_scnt;
    logic [6:0]          r_bcnt;
    logic [7:0]          r_fcnt;
    logic [7:0]          r_nframes;
    logic                r_out_valid;
    logic signed [W-1:0] r_out_re;
    logic signed [W-1:0] r_out_im;
    logic [5:0]          r_out_idx;

    logic signed [W-1:0] w_re;
    logic signed [W-1:0] w_im;
    logic w_valid_a, w_xfer, w_last_sample, w_accept, w_last_bin, w_last_frame;
    logic w_reader_en, w_rd_en, w_frame_done;

    fft64_word_unpack u_unpack (
        .i_word (r_buf),
        .i_sidx (r_sidx),
        .o_re   (w_re),
        .o_im   (w_im)
    );

    assign w_valid_a     = (r_state == ST_FEED);
    assign w_xfer        = w_valid_a && !bus.full;
    assign w_last_sample = (r_sidx == SIDX_W'(SPW - 1));
    assign w_accept      = r_out_valid && bus.out_ready;
    assign w_last_bin    = w_accept && (r_out_idx == 6'(N - 1));
    assign w_last_frame  = ((r_fcnt + 8'd1) == r_nframes);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_reader_en  = 1'b0;
        w_rd_en      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (r_fetch_pend)           w_state_next = ST_FEED;
                else if (!bus.reader_empty) w_reader_en  = 1'b1;
            end
            ST_FEED: begin
                if (w_xfer && w_last_sample)
                    w_state_next = (r_scnt == 7'(N - 1)) ? ST_DRAIN : ST_FETCH;
            end
            ST_DRAIN: begin
                // Never pull a bin past the frame's last one while it is still held.
                w_rd_en = bus.valid_o &&
                          (!r_out_valid || (bus.out_ready && r_out_idx != 6'(N - 1)));
                w_frame_done = w_last_bin;
                if (w_last_bin) w_state_next = w_last_frame ? ST_IDLE : ST_FETCH;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_pend <= 1'b0;
            r_buf        <= '0;
            r_sidx       <= '0;
            r_scnt       <= '0;
            r_bcnt       <= '0;
            r_fcnt       <= '0;
            r_nframes    <= '0;
            r_out_valid  <= 1'b0;
            r_out_re     <= '0;
            r_out_im     <= '0;
            r_out_idx    <= '0;
        end else begin
            r_fetch_pend <= w_reader_en;
            if (r_state == ST_IDLE && bus.start) begin
                r_nframes <= (bus.nframes == 8'd0) ? 8'd1 : bus.nframes;
                r_fcnt    <= '0;
                r_scnt    <= '0;
                r_bcnt    <= '0;
                r_sidx    <= '0;
            end
            if (r_state == ST_FETCH && r_fetch_pend) begin
                r_buf  <= bus.reader_data;
                r_sidx <= '0;
            end
            if (w_xfer) begin
                r_sidx <= r_sidx + SIDX_W'(1);
                r_scnt <= (r_scnt == 7'(N - 1)) ? 7'd0 : r_scnt + 7'd1;
            end
            if (w_accept) r_out_valid <= 1'b0;
            if (w_rd_en) begin
                r_out_valid <= 1'b1;
                r_out_re    <= bus.xr;
                r_out_im    <= bus.xi;
                r_out_idx   <= r_bcnt[5:0];
                r_bcnt      <= (r_bcnt == 7'(N - 1)) ? 7'd0 : r_bcnt + 7'd1;
            end
            if (w_last_bin && !w_last_frame) r_fcnt <= r_fcnt + 8'd1;
        end
    end

    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.reader_en  = w_reader_en;
    assign bus.valid_a    = w_valid_a;
    assign bus.ar         = w_valid_a ? w_re : '0;
    assign bus.ai         = w_valid_a ? w_im : '0;
    assign bus.rd_en      = w_rd_en;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_re     = r_out_re;
    assign bus.out_im     = r_out_im;
    assign bus.out_idx    = r_out_idx;
    assign bus.frame_done = w_frame_done;
endmodule
